vga_pattern_sequencer: RTL and testbench

Control block that selects which test pattern the VGA colour-bar generator draws, and when it switches. It sits between the timing generator (frame_start pulse) and the pattern datapath (pattern_sel). It supports manual stepping from a debounced push-button, automatic cycling every N frames, and a freeze mode. Pattern changes are applied only on frame boundaries, so a frame never tears.

---
 rtl/vga_pattern_sequencer.sv | 168 ++++++++++++++++
 tb/tb_vga_pattern_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer for the VGA colour-bar generator: manual/auto/freeze selection, frame-aligned switching.
// Optional feature macro: SCROLL_OFFSET_EN (adds the scroll_offset output and its counter).
module vga_pattern_sequencer #(
    parameter int NUM_PATTERNS       = 6,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int DEBOUNCE_CYCLES    = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic       freeze,
`ifdef SCROLL_OFFSET_EN
    output logic [9:0] scroll_offset,
`endif
    output logic [2:0] pattern_sel,
    output logic       pattern_changed,
    output logic [7:0] frame_cnt
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    function automatic logic [2:0] next_pattern(input logic [2:0] cur);
        if (cur == 3'(NUM_PATTERNS - 1)) begin
            next_pattern = 3'd0;
        end else begin
            next_pattern = cur + 3'd1;
        end
    endfunction

    logic           sync1_r, sync2_r;
    logic [DBW-1:0] db_cnt_r, db_cnt_nxt_s;
    logic           db_level_r, db_level_nxt_s;
    logic           press_s;
    logic           pending_r, pending_nxt_s;
    state_t         state_r, state_s;
    logic [2:0]     pattern_sel_r, pattern_sel_nxt_s;
    logic           pattern_changed_r;
    logic [7:0]     frame_cnt_r, frame_cnt_nxt_s, cnt_eff_s;
    logic           advance_s;
`ifdef SCROLL_OFFSET_EN
    logic [9:0]     scroll_r, scroll_nxt_s;
`endif

    // Debounce: the accepted level flips only after a full run of stable synchronised samples.
    always_comb begin
        db_cnt_nxt_s   = '0;
        db_level_nxt_s = db_level_r;
        press_s        = 1'b0;
        if (sync2_r == db_level_r) begin
            db_cnt_nxt_s = '0;
        end else if (db_cnt_r == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db_level_nxt_s = ~db_level_r;
            db_cnt_nxt_s   = '0;
            press_s        = sync2_r;
        end else begin
            db_cnt_nxt_s = db_cnt_r + DBW'(1);
        end
    end

    // Mode decode plus frame-aligned advance/count decisions.
    always_comb begin
        state_s           = ST_MANUAL;
        advance_s         = 1'b0;
        frame_cnt_nxt_s   = frame_cnt_r;
        // a fresh entry into AUTO (from any other mode) counts from zero
        cnt_eff_s         = (state_r == ST_AUTO) ? frame_cnt_r : 8'd0;
        if (freeze) begin
            state_s = ST_FROZEN;
        end else if (auto_en) begin
            state_s = ST_AUTO;
        end else begin
            state_s = ST_MANUAL;
        end
        case (state_s)
            ST_MANUAL: begin
                frame_cnt_nxt_s = 8'd0;
                if (frame_start && pending_r) begin
                    advance_s = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
            end
            ST_AUTO: begin
                frame_cnt_nxt_s = cnt_eff_s;
                if (frame_start) begin
                    if (pending_r || (cnt_eff_s == 8'(FRAMES_PER_PATTERN - 1))) begin
                        advance_s       = 1'b1;
                        frame_cnt_nxt_s = 8'd0;
                    end else begin
                        frame_cnt_nxt_s = cnt_eff_s + 8'd1;
                    end
                end else begin
                    frame_cnt_nxt_s = cnt_eff_s;
                end
            end
            ST_FROZEN: begin
                frame_cnt_nxt_s = frame_cnt_r;
            end
            default: begin
                frame_cnt_nxt_s = 8'd0;
            end
        endcase
        // a press completing during the consuming frame_start survives for the next frame
        pending_nxt_s     = (advance_s ? 1'b0 : pending_r) | press_s;
        pattern_sel_nxt_s = advance_s ? next_pattern(pattern_sel_r) : pattern_sel_r;
    end

`ifdef SCROLL_OFFSET_EN
    // Scroll offset: cleared by an advance, otherwise stepped once per non-frozen frame.
    always_comb begin
        scroll_nxt_s = scroll_r;
        if (advance_s) begin
            scroll_nxt_s = 10'd0;
        end else if (frame_start && (state_s != ST_FROZEN)) begin
            scroll_nxt_s = scroll_r + 10'd1;
        end else begin
            scroll_nxt_s = scroll_r;
        end
    end

    // Scroll offset register.
    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_r <= 10'd0;
        end else begin
            scroll_r <= scroll_nxt_s;
        end
    end

    assign scroll_offset = scroll_r;
`endif

    // State registers for the button path, FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r           <= 1'b0;
            sync2_r           <= 1'b0;
            db_cnt_r          <= '0;
            db_level_r        <= 1'b0;
            pending_r         <= 1'b0;
            state_r           <= ST_MANUAL;
            pattern_sel_r     <= 3'd0;
            pattern_changed_r <= 1'b0;
            frame_cnt_r       <= 8'd0;
        end else begin
            sync1_r           <= btn_next;
            sync2_r           <= sync1_r;
            db_cnt_r          <= db_cnt_nxt_s;
            db_level_r        <= db_level_nxt_s;
            pending_r         <= pending_nxt_s;
            state_r           <= state_s;
            pattern_sel_r     <= pattern_sel_nxt_s;
            pattern_changed_r <= advance_s;
            frame_cnt_r       <= frame_cnt_nxt_s;
        end
    end

    assign pattern_sel     = pattern_sel_r;
    assign pattern_changed = pattern_changed_r;
    assign frame_cnt       = frame_cnt_r;
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer: directed scenarios then randomized operations against
// an event-level reference model (presses, frames, mode changes, resets).
module tb_vga_pattern_sequencer;
    localparam int NP  = 4;
    localparam int FPP = 3;
    localparam int DB  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic       freeze = 1'b0;
    logic [2:0] pattern_sel;
    logic       pattern_changed;
    logic [7:0] frame_cnt;
`ifdef SCROLL_OFFSET_EN
    logic [9:0] scroll_offset;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int  m_sel = 0, m_cnt = 0, m_scroll = 0;
    bit  m_pend = 1'b0;
    int  m_mode = 0;  // 0 manual, 1 auto, 2 frozen

    vga_pattern_sequencer #(
        .NUM_PATTERNS(NP), .FRAMES_PER_PATTERN(FPP), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .btn_next(btn_next),
        .auto_en(auto_en), .freeze(freeze),
`ifdef SCROLL_OFFSET_EN
        .scroll_offset(scroll_offset),
`endif
        .pattern_sel(pattern_sel), .pattern_changed(pattern_changed), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outputs(input string tag, input int exp_changed);
        check({tag, ".sel"}, int'(pattern_sel), m_sel);
        check({tag, ".chg"}, int'(pattern_changed), exp_changed);
        check({tag, ".cnt"}, int'(frame_cnt), m_cnt);
`ifdef SCROLL_OFFSET_EN
        check({tag, ".scroll"}, int'(scroll_offset), m_scroll);
`endif
    endtask

    task automatic do_frame(input string tag);
        bit adv;
        adv = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        if (m_mode == 0) begin
            adv   = m_pend;
            m_cnt = 0;
        end else if (m_mode == 1) begin
            if (m_pend || m_cnt == FPP - 1) begin
                adv   = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (adv) begin
            m_sel    = (m_sel + 1) % NP;
            m_pend   = 1'b0;
            m_scroll = 0;
        end else if (m_mode != 2) begin
            m_scroll = (m_scroll + 1) % 1024;
        end
        check_outputs(tag, int'(adv));
        tick(1);
        check({tag, ".chg_drop"}, int'(pattern_changed), 0);
        tick(1);
    endtask

    task automatic do_press();
        btn_next = 1'b1;
        tick(10);
        btn_next = 1'b0;
        tick(10);
        m_pend = 1'b1;
    endtask

    task automatic do_glitch(input int len);
        btn_next = 1'b1;
        tick(len);
        btn_next = 1'b0;
        tick(8);
    endtask

    task automatic set_mode(input bit a, input bit f);
        int nm;
        auto_en = a;
        freeze  = f;
        nm = f ? 2 : (a ? 1 : 0);
        if (nm == 0 || (nm == 1 && m_mode != 1)) m_cnt = 0;
        m_mode = nm;
        tick(2);
        check_outputs("mode", 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_sel = 0; m_cnt = 0; m_pend = 1'b0; m_scroll = 0;
        check_outputs("reset", 0);
        tick(1);
    endtask

    initial begin
        int op;
        tick(2);
        rst = 1'b0;
        check_outputs("por", 0);

        // 1: manual, no button
        for (int i = 0; i < 10; i++) do_frame("t1");
        check("t1.sel_const", int'(pattern_sel), 0);

        // 2: bouncing press -> one advance; short glitch alone -> none
        btn_next = 1'b1; tick(2);
        btn_next = 1'b0; tick(1);
        btn_next = 1'b1; tick(10);
        btn_next = 1'b0; tick(10);
        m_pend = 1'b1;
        do_frame("t2");
        check("t2.sel_const", int'(pattern_sel), 1);
        do_glitch(2);
        do_frame("t2g");
        check("t2g.sel_const", int'(pattern_sel), 1);

        // 3: auto cycling from pattern 0
        do_reset();
        set_mode(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) do_frame("t3");
        check("t3.sel_const", int'(pattern_sel), 0);

        // 4: press pending with frame_cnt==2 -> single advance
        do_frame("t4a");
        do_frame("t4b");
        check("t4.cnt_const", int'(frame_cnt), 2);
        do_press();
        do_frame("t4");
        check("t4.sel_const", int'(pattern_sel), 1);
        check("t4.cnt0_const", int'(frame_cnt), 0);

        // 5: freeze holds, pending retained
        do_frame("t5pre");
        set_mode(1'b1, 1'b1);
        do_press();
        for (int i = 0; i < 5; i++) do_frame("t5f");
        set_mode(1'b1, 1'b0);
        do_frame("t5");

        // 6: reset discards a pending press
        while (m_sel != 3) do_frame("t6pre");
        do_press();
        do_reset();
        do_frame("t6");
        check("t6.sel_const", int'(pattern_sel), 0);
        set_mode(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_frame("t6s");
        do_press();
        do_frame("t6adv");

        // randomized operations
        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 99);
            if (op < 50) do_frame("rnd");
            else if (op < 65) do_press();
            else if (op < 75) do_glitch($urandom_range(1, 2));
            else if (op < 92) set_mode(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            else if (op < 95) do_reset();
            else tick($urandom_range(1, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
